// File: rtl/rtc_bus_sequencer.sv
// RTC-side bus transaction engine: runs three address/data byte transactions on
// the multiplexed RTC bus for a write (Escribe) or read (Lee) request.
module rtc_bus_sequencer #(
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_GAP   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Escribe,
    input  logic       Lee,
    input  logic [7:0] Dir_hora,
    input  logic [7:0] Dir_minuto,
    input  logic [7:0] Dir_segundo,
    input  logic [7:0] hora,
    input  logic [7:0] minuto,
    input  logic [7:0] segundo,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       CS_n,
    output logic       WR_n,
    output logic       RD_n,
    output logic       AD_n,
    output logic       T_Esc,
    output logic       T_Lect,
    output logic [7:0] rd_hora,
    output logic [7:0] rd_minuto,
    output logic [7:0] rd_segundo,
    output logic       busy
);

    localparam int unsigned T_MAX = (T_PULSE > T_GAP) ? T_PULSE : T_GAP;
    localparam int unsigned CW    = $clog2(T_MAX + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(T_GAP - 1);

    typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D, DONE} state_t;
    typedef enum logic {MODE_WR, MODE_RD} mode_t;

    state_t        state_q;
    mode_t         mode_q;
    logic [1:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    addr_q [3];
    logic [7:0]    data_q [3];
    logic [7:0]    rd_q   [3];

    logic [7:0]    ad_out_q;
    logic          ad_oe_q;
    logic          cs_n_q;
    logic          wr_n_q;
    logic          rd_n_q;
    logic          ad_n_q;
    logic          t_esc_q;
    logic          t_lect_q;
    logic          busy_q;

    logic          pulse_end_d;
    logic          gap_end_d;
    logic [1:0]    idx_inc_d;
    logic [7:0]    addr_next_d;
    logic [7:0]    data_cur_d;

    function automatic logic [7:0] pick(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [1:0] i);
        case (i)
            2'd0:    pick = b0;
            2'd1:    pick = b1;
            default: pick = b2;
        endcase
    endfunction

    always_comb begin
        pulse_end_d = (cnt_q == PULSE_LAST);
        gap_end_d   = (cnt_q == GAP_LAST);
        idx_inc_d   = idx_q + 2'd1;
        addr_next_d = pick(addr_q[0], addr_q[1], addr_q[2], idx_inc_d);
        data_cur_d  = pick(data_q[0], data_q[1], data_q[2], idx_q);
    end

    // Outputs are loaded on the edge that enters each state, so every bus
    // signal changes only at phase boundaries.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            mode_q   <= MODE_WR;
            idx_q    <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            rd_n_q   <= 1'b1;
            ad_n_q   <= 1'b1;
            t_esc_q  <= 1'b0;
            t_lect_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            t_esc_q  <= 1'b0;
            t_lect_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (Escribe || Lee) begin
                        mode_q    <= Escribe ? MODE_WR : MODE_RD;
                        addr_q[0] <= Dir_hora;
                        addr_q[1] <= Dir_minuto;
                        addr_q[2] <= Dir_segundo;
                        data_q[0] <= hora;
                        data_q[1] <= minuto;
                        data_q[2] <= segundo;
                        idx_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= ADDR;
                        cs_n_q    <= 1'b0;
                        ad_n_q    <= 1'b0;
                        wr_n_q    <= 1'b0;
                        ad_oe_q   <= 1'b1;
                        ad_out_q  <= Dir_hora;
                        busy_q    <= 1'b1;
                    end
                end
                ADDR: begin
                    if (pulse_end_d) begin
                        cnt_q   <= '0;
                        state_q <= GAP_A;
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        ad_n_q  <= 1'b1;
                        ad_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP_A: begin
                    if (gap_end_d) begin
                        cnt_q   <= '0;
                        state_q <= DATA;
                        cs_n_q  <= 1'b0;
                        ad_n_q  <= 1'b1;
                        if (mode_q == MODE_WR) begin
                            wr_n_q   <= 1'b0;
                            ad_oe_q  <= 1'b1;
                            ad_out_q <= data_cur_d;
                        end else begin
                            rd_n_q  <= 1'b0;
                            ad_oe_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (pulse_end_d) begin
                        if (mode_q == MODE_RD) begin
                            case (idx_q)
                                2'd0:    rd_q[0] <= ad_in;
                                2'd1:    rd_q[1] <= ad_in;
                                default: rd_q[2] <= ad_in;
                            endcase
                        end
                        cnt_q   <= '0;
                        state_q <= GAP_D;
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        rd_n_q  <= 1'b1;
                        ad_n_q  <= 1'b1;
                        ad_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                GAP_D: begin
                    if (gap_end_d) begin
                        cnt_q <= '0;
                        if (idx_q == 2'd2) begin
                            state_q  <= DONE;
                            t_esc_q  <= (mode_q == MODE_WR);
                            t_lect_q <= (mode_q == MODE_RD);
                        end else begin
                            idx_q    <= idx_inc_d;
                            state_q  <= ADDR;
                            cs_n_q   <= 1'b0;
                            ad_n_q   <= 1'b0;
                            wr_n_q   <= 1'b0;
                            ad_oe_q  <= 1'b1;
                            ad_out_q <= addr_next_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ad_out     = ad_out_q;
    assign ad_oe      = ad_oe_q;
    assign CS_n       = cs_n_q;
    assign WR_n       = wr_n_q;
    assign RD_n       = rd_n_q;
    assign AD_n       = ad_n_q;
    assign T_Esc      = t_esc_q;
    assign T_Lect     = t_lect_q;
    assign rd_hora    = rd_q[0];
    assign rd_minuto  = rd_q[1];
    assign rd_segundo = rd_q[2];
    assign busy       = busy_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer: table of full transactions checked
// cycle by cycle against a timeline, plus reset-abort and short-timing sequences.
module tb_rtc_bus_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       Escribe, Lee;
    logic [7:0] Dir_hora, Dir_minuto, Dir_segundo, hora, minuto, segundo, ad_in;
    logic [7:0] ad_out, rd_hora, rd_minuto, rd_segundo;
    logic       ad_oe, CS_n, WR_n, RD_n, AD_n, T_Esc, T_Lect, busy;

    logic       f_Escribe, f_Lee;
    logic [7:0] f_Dir_hora, f_Dir_minuto, f_Dir_segundo, f_hora, f_minuto, f_segundo, f_ad_in;
    logic [7:0] f_ad_out, f_rd_hora, f_rd_minuto, f_rd_segundo;
    logic       f_ad_oe, f_CS_n, f_WR_n, f_RD_n, f_AD_n, f_T_Esc, f_T_Lect, f_busy;

    rtc_bus_sequencer u_dut (
        .clk(clk), .reset(reset), .Escribe(Escribe), .Lee(Lee),
        .Dir_hora(Dir_hora), .Dir_minuto(Dir_minuto), .Dir_segundo(Dir_segundo),
        .hora(hora), .minuto(minuto), .segundo(segundo), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n),
        .AD_n(AD_n), .T_Esc(T_Esc), .T_Lect(T_Lect), .rd_hora(rd_hora),
        .rd_minuto(rd_minuto), .rd_segundo(rd_segundo), .busy(busy)
    );

    rtc_bus_sequencer #(.T_PULSE(1), .T_GAP(1)) u_fast (
        .clk(clk), .reset(reset), .Escribe(f_Escribe), .Lee(f_Lee),
        .Dir_hora(f_Dir_hora), .Dir_minuto(f_Dir_minuto), .Dir_segundo(f_Dir_segundo),
        .hora(f_hora), .minuto(f_minuto), .segundo(f_segundo), .ad_in(f_ad_in),
        .ad_out(f_ad_out), .ad_oe(f_ad_oe), .CS_n(f_CS_n), .WR_n(f_WR_n), .RD_n(f_RD_n),
        .AD_n(f_AD_n), .T_Esc(f_T_Esc), .T_Lect(f_T_Lect), .rd_hora(f_rd_hora),
        .rd_minuto(f_rd_minuto), .rd_segundo(f_rd_segundo), .busy(f_busy)
    );

    // {CS_n, WR_n, RD_n, AD_n, ad_oe, busy, T_Esc, T_Lect}
    localparam logic [7:0] C_IDLE  = 8'b1111_0000;
    localparam logic [7:0] C_ADDR  = 8'b0010_1100;
    localparam logic [7:0] C_GAP   = 8'b1111_0100;
    localparam logic [7:0] C_DWR   = 8'b0011_1100;
    localparam logic [7:0] C_DRD   = 8'b0101_0100;
    localparam logic [7:0] C_DONEW = 8'b1111_0110;
    localparam logic [7:0] C_DONER = 8'b1111_0101;

    typedef struct {
        string       name;
        logic        esc;
        logic        lee;
        logic [23:0] addr;
        logic [23:0] data;
        logic [23:0] rtc;
        logic        is_write;
        logic [47:0] exp_bus;
        logic [23:0] exp_rd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [7:0] ctl();
        return {CS_n, WR_n, RD_n, AD_n, ad_oe, busy, T_Esc, T_Lect};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] ctl_exp;
        logic [7:0] bus_exp;
        logic       chk_bus;
        int         b, off;
        @(negedge clk);
        Escribe = v.esc; Lee = v.lee;
        Dir_hora = v.addr[23:16]; Dir_minuto = v.addr[15:8]; Dir_segundo = v.addr[7:0];
        hora = v.data[23:16]; minuto = v.data[15:8]; segundo = v.data[7:0];
        ad_in = 8'hEE;
        @(posedge clk);
        @(negedge clk);
        // Request dropped and all latched inputs scrambled once the sequence has started.
        Escribe = 1'b0; Lee = 1'b0;
        Dir_hora = ~v.addr[23:16]; Dir_minuto = ~v.addr[15:8]; Dir_segundo = ~v.addr[7:0];
        hora = ~v.data[23:16]; minuto = ~v.data[15:8]; segundo = ~v.data[7:0];
        for (int j = 0; j <= 91; j++) begin
            if (j > 0) @(negedge clk);
            b = j / 30; off = j % 30;
            chk_bus = 1'b0; bus_exp = 8'h00; ad_in = 8'hEE;
            if (j == 90)      ctl_exp = v.is_write ? C_DONEW : C_DONER;
            else if (j == 91) ctl_exp = C_IDLE;
            else if (off < 10) begin
                ctl_exp = C_ADDR; chk_bus = 1'b1;
                bus_exp = v.exp_bus[47 - 16*b -: 8];
            end else if (off < 15) ctl_exp = C_GAP;
            else if (off < 25) begin
                if (v.is_write) begin
                    ctl_exp = C_DWR; chk_bus = 1'b1;
                    bus_exp = v.exp_bus[39 - 16*b -: 8];
                end else begin
                    ctl_exp = C_DRD;
                    ad_in = (off == 24) ? v.rtc[23 - 8*b -: 8] : (v.rtc[23 - 8*b -: 8] ^ 8'h5A);
                end
            end else ctl_exp = C_GAP;
            check($sformatf("%s ctl j=%0d", v.name, j), {24'd0, ctl()}, {24'd0, ctl_exp});
            if (chk_bus) check($sformatf("%s ad_out j=%0d", v.name, j), {24'd0, ad_out}, {24'd0, bus_exp});
        end
        check({v.name, " rd"}, {8'd0, rd_hora, rd_minuto, rd_segundo}, {8'd0, v.exp_rd});
    endtask

    vec_t vecs [4];
    vec_t post;
    int   f_first, f_second, f_cnt, f_done;
    logic t_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"wr1",  1'b1, 1'b0, 24'h232221, 24'h123456, 24'h000000, 1'b1, 48'h23_12_22_34_21_56, 24'h000000};
        vecs[1] = '{"rd1",  1'b0, 1'b1, 24'h434241, 24'h999999, 24'h093045, 1'b0, 48'h43_00_42_00_41_00, 24'h093045};
        vecs[2] = '{"both", 1'b1, 1'b1, 24'h313233, 24'hAA550F, 24'h000000, 1'b1, 48'h31_AA_32_55_33_0F, 24'h093045};
        vecs[3] = '{"rd2",  1'b0, 1'b1, 24'h010203, 24'h000000, 24'hFF00A5, 1'b0, 48'h01_00_02_00_03_00, 24'hFF00A5};

        reset = 1'b0; Escribe = 1'b0; Lee = 1'b0; ad_in = 8'h00;
        Dir_hora = 8'h00; Dir_minuto = 8'h00; Dir_segundo = 8'h00;
        hora = 8'h00; minuto = 8'h00; segundo = 8'h00;
        f_Escribe = 1'b0; f_Lee = 1'b0; f_ad_in = 8'h00;
        f_Dir_hora = 8'h0A; f_Dir_minuto = 8'h0B; f_Dir_segundo = 8'h0C;
        f_hora = 8'h1D; f_minuto = 8'h1E; f_segundo = 8'h1F;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("reset ctl c%0d", i), {24'd0, ctl()}, {24'd0, C_IDLE});
            check($sformatf("reset bus c%0d", i), {24'd0, ad_out}, 32'd0);
            check($sformatf("reset rd c%0d", i), {8'd0, rd_hora, rd_minuto, rd_segundo}, 32'd0);
        end

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Reset during byte 1 DATA phase of a read; byte 0 already captured.
        @(negedge clk);
        Lee = 1'b1; Dir_hora = 8'h50; Dir_minuto = 8'h51; Dir_segundo = 8'h52; ad_in = 8'h77;
        @(posedge clk);
        @(negedge clk);
        Lee = 1'b0;
        for (int j = 1; j <= 48; j++) @(negedge clk);
        check("abort pre rd_hora", {24'd0, rd_hora}, 32'h77);
        check("abort pre ctl", {24'd0, ctl()}, {24'd0, C_DRD});
        reset = 1'b0;
        @(negedge clk);
        check("abort ctl", {24'd0, ctl()}, {24'd0, C_IDLE});
        check("abort rd", {8'd0, rd_hora, rd_minuto, rd_segundo}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        t_seen = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (T_Esc || T_Lect || busy) t_seen = 1'b1;
        end
        check("abort no T pulse", {31'd0, t_seen}, 32'd0);
        post = '{"rd_post", 1'b0, 1'b1, 24'h434241, 24'h000000, 24'h123456, 1'b0, 48'h43_00_42_00_41_00, 24'h123456};
        run_vec(post);

        // Short timing: Escribe held high re-triggers after one IDLE cycle.
        @(negedge clk);
        f_Escribe = 1'b1;
        @(posedge clk);
        f_first = -1; f_second = -1; f_cnt = 0; t_seen = 1'b0;
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            if (j == 0)  check("fast ad_out a0", {24'd0, f_ad_out}, 32'h0A);
            if (j == 2)  check("fast ad_out d0", {24'd0, f_ad_out}, 32'h1D);
            if (j == 4)  check("fast ad_out a1", {24'd0, f_ad_out}, 32'h0B);
            if (j == 10) check("fast ad_out d2", {24'd0, f_ad_out}, 32'h1F);
            if (f_T_Lect) t_seen = 1'b1;
            if (f_T_Esc) begin
                if (f_cnt == 0) f_first = j; else if (f_cnt == 1) f_second = j;
                f_cnt++;
            end
        end
        f_Escribe = 1'b0;
        check("fast T_Esc first", f_first, 32'd12);
        check("fast T_Esc retrigger", f_second, 32'd26);
        check("fast T_Esc count", f_cnt, 32'd2);
        check("fast no T_Lect on write", {31'd0, t_seen}, 32'd0);
        repeat (20) @(negedge clk);

        f_Lee = 1'b1;
        @(posedge clk);
        @(negedge clk);
        f_Lee = 1'b0;
        f_done = -1;
        for (int j = 0; j < 30; j++) begin
            if (j > 0) @(negedge clk);
            f_ad_in = (j == 2) ? 8'h11 : (j == 6) ? 8'h22 : (j == 10) ? 8'h33 : 8'hEE;
            if (f_T_Lect && f_done < 0) f_done = j;
        end
        check("fast T_Lect cycle", f_done, 32'd12);
        check("fast rd", {8'd0, f_rd_hora, f_rd_minuto, f_rd_segundo}, 32'h112233);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
